// File: rtl/flash_boot_loader.sv
// Boot copier: reads LEN bytes from SPI flash (READ 0x03, mode 0) into SRAM while
// holding the CPU in reset, then releases it. Re-armed by a reload pulse once done.
module flash_boot_loader #(
   parameter int          CLK_DIV     = 2,
   parameter int          START_DELAY = 16,
   parameter logic [23:0] FLASH_BASE  = 24'h010000,
   parameter logic [18:0] SRAM_BASE   = 19'h00000,
   parameter int          LEN         = 32768
) (
   input  logic        CLK,
   input  logic        RESB,
   input  logic        reload,
   output logic        flash_csb,
   output logic        flash_clk,
   output logic        flash_mosi,
   input  logic        flash_miso,
   output logic [18:0] sram_adr,
   output logic [7:0]  sram_wdata,
   output logic        sram_wreq,
   input  logic        sram_wack,
   output logic        cpu_resb,
   output logic        busy,
   output logic        done,
   output logic [17:0] byte_count
);

   localparam int CNT_W = $clog2(START_DELAY + 2);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int WAIT_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;
   localparam logic [CNT_W-1:0] WAIT_LAST_C = CNT_W'(WAIT_LAST);
   localparam logic [DIV_W-1:0] DIV_LAST_C  = DIV_W'(CLK_DIV - 1);
   localparam logic [17:0]      LEN_C       = 18'(LEN);
   localparam logic [31:0]      CMD_WORD    = {8'h03, FLASH_BASE};

   typedef enum logic [2:0] {
      S_WAIT  = 3'd0,
      S_CMD   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [4:0]       bit_q, bit_d;
   logic [31:0]      sr_q, sr_d;
   logic [7:0]       rx_q, rx_d;
   logic             csb_q, csb_d;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;
   logic             wreq_q, wreq_d;
   logic [18:0]      adr_q, adr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic             cpu_resb_q, cpu_resb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [17:0]      count_q, count_d;
   logic [17:0]      count_inc;
   logic             sck_tick;

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         state_q    <= S_WAIT;
         cnt_q      <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         sr_q       <= '0;
         rx_q       <= '0;
         csb_q      <= 1'b1;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         wreq_q     <= 1'b0;
         adr_q      <= SRAM_BASE;
         wdata_q    <= '0;
         cpu_resb_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         sr_q       <= sr_d;
         rx_q       <= rx_d;
         csb_q      <= csb_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         wreq_q     <= wreq_d;
         adr_q      <= adr_d;
         wdata_q    <= wdata_d;
         cpu_resb_q <= cpu_resb_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      bit_d     = bit_q;
      sr_d      = sr_q;
      rx_d      = rx_q;
      csb_d     = csb_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      wreq_d    = wreq_q;
      adr_d     = adr_q;
      wdata_d   = wdata_q;
      count_d   = count_q;
      count_inc = count_q + 18'd1;
      sck_tick  = (div_q == DIV_LAST_C);

      unique case (state_q)
         S_WAIT: begin
            if (cnt_q == WAIT_LAST_C) begin
               cnt_d = '0;
               if (LEN_C == 18'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_CMD;
                  csb_d   = 1'b0;
                  sr_d    = CMD_WORD;
                  mosi_d  = CMD_WORD[31];
                  div_d   = '0;
                  bit_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CMD: begin
            if (sck_tick) begin
               div_d = '0;
               sck_d = ~sck_q;
               // MOSI only moves on the falling SCK edge (mode 0)
               if (sck_q) begin
                  if (bit_q == 5'd31) begin
                     state_d = S_DATA;
                     mosi_d  = 1'b0;
                     bit_d   = '0;
                  end else begin
                     sr_d   = {sr_q[30:0], 1'b0};
                     mosi_d = sr_q[30];
                     bit_d  = bit_q + 5'd1;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_DATA: begin
            if (sck_tick) begin
               div_d = '0;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_d = {rx_q[6:0], flash_miso};
               end else if (bit_q == 5'd7) begin
                  wdata_d = rx_q;
                  wreq_d  = 1'b1;
                  bit_d   = '0;
                  state_d = S_WRITE;
               end else begin
                  bit_d = bit_q + 5'd1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_WRITE: begin
            // CSB stays low so the flash keeps streaming from the next address
            if (sram_wack) begin
               wreq_d  = 1'b0;
               count_d = count_inc;
               adr_d   = adr_q + 19'd1;
               div_d   = '0;
               if (count_inc == LEN_C) begin
                  state_d = S_DONE;
                  csb_d   = 1'b1;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DONE: begin
            csb_d  = 1'b1;
            sck_d  = 1'b0;
            mosi_d = 1'b0;
            if (reload) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               count_d = '0;
               adr_d   = SRAM_BASE;
            end
         end
         default: state_d = S_WAIT;
      endcase

      busy_d     = (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      cpu_resb_d = (state_q == S_DONE) && (state_d == S_DONE);
   end

   assign flash_csb  = csb_q;
   assign flash_clk  = sck_q;
   assign flash_mosi = mosi_q;
   assign sram_adr   = adr_q;
   assign sram_wdata = wdata_q;
   assign sram_wreq  = wreq_q;
   assign cpu_resb   = cpu_resb_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign byte_count = count_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Randomized scoreboard bench: a behavioural SPI flash, a random-latency SRAM acceptor,
// and an expected-write queue drained by a monitor; a wrap-address twin and a LEN=0 twin run alongside.
module tb_flash_boot_loader;

   localparam logic [23:0] FB   = 24'h010000;
   localparam logic [18:0] SB0  = 19'h00000;
   localparam logic [18:0] SBW  = 19'h7FFFE;
   localparam int          NLEN = 4;

   logic CLK = 1'b0;
   logic RESB = 1'b0;
   logic reload = 1'b0;
   logic flash_miso = 1'b0;
   logic sram_wack = 1'b0;

   logic        flash_csb, flash_clk, flash_mosi, sram_wreq, cpu_resb, busy, done;
   logic [18:0] sram_adr;
   logic [7:0]  sram_wdata;
   logic [17:0] byte_count;

   logic        w_csb, w_clk, w_mosi, w_wreq, w_cpu_resb, w_busy, w_done;
   logic [18:0] w_adr;
   logic [7:0]  w_wdata;
   logic [17:0] w_count;

   logic        z_csb, z_clk, z_mosi, z_wreq, z_cpu_resb, z_busy, z_done;
   logic [18:0] z_adr;
   logic [7:0]  z_wdata;
   logic [17:0] z_count;

   flash_boot_loader #(.CLK_DIV(2), .START_DELAY(16), .FLASH_BASE(FB), .SRAM_BASE(SB0), .LEN(NLEN)) dut (
      .CLK(CLK), .RESB(RESB), .reload(reload), .flash_csb(flash_csb), .flash_clk(flash_clk),
      .flash_mosi(flash_mosi), .flash_miso(flash_miso), .sram_adr(sram_adr), .sram_wdata(sram_wdata),
      .sram_wreq(sram_wreq), .sram_wack(sram_wack), .cpu_resb(cpu_resb), .busy(busy), .done(done),
      .byte_count(byte_count));

   flash_boot_loader #(.CLK_DIV(2), .START_DELAY(16), .FLASH_BASE(FB), .SRAM_BASE(SBW), .LEN(NLEN)) dut_wrap (
      .CLK(CLK), .RESB(RESB), .reload(reload), .flash_csb(w_csb), .flash_clk(w_clk),
      .flash_mosi(w_mosi), .flash_miso(flash_miso), .sram_adr(w_adr), .sram_wdata(w_wdata),
      .sram_wreq(w_wreq), .sram_wack(sram_wack), .cpu_resb(w_cpu_resb), .busy(w_busy), .done(w_done),
      .byte_count(w_count));

   flash_boot_loader #(.CLK_DIV(2), .START_DELAY(16), .FLASH_BASE(FB), .SRAM_BASE(SB0), .LEN(0)) dut_len0 (
      .CLK(CLK), .RESB(RESB), .reload(reload), .flash_csb(z_csb), .flash_clk(z_clk),
      .flash_mosi(z_mosi), .flash_miso(1'b0), .sram_adr(z_adr), .sram_wdata(z_wdata),
      .sram_wreq(z_wreq), .sram_wack(1'b0), .cpu_resb(z_cpu_resb), .busy(z_busy), .done(z_done),
      .byte_count(z_count));

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK) cyc++;

   // Flash contents; low address byte selects the location
   logic [7:0] fmem [0:255];

   typedef struct {
      logic [18:0] adr;
      logic [18:0] adr_w;
      logic [7:0]  data;
   } exp_t;
   exp_t exq[$];

   task automatic push_copy();
      exp_t e;
      exq.delete();
      for (int i = 0; i < NLEN; i++) begin
         e.adr   = 19'(SB0 + 19'(i));
         e.adr_w = 19'(SBW + 19'(i));
         e.data  = fmem[8'(FB + 24'(i))];
         exq.push_back(e);
      end
   endtask

   // Behavioural SPI flash: capture the 32-bit command, then stream bytes from its address
   int          ncmd = 0;
   int          bitpos = 0;
   logic [31:0] cmd = '0;
   logic [23:0] rd_addr = '0;

   always @(negedge flash_csb) begin
      ncmd   = 0;
      bitpos = 0;
   end

   always @(posedge flash_clk) begin
      if (!flash_csb && ncmd < 32) begin
         cmd = {cmd[30:0], flash_mosi};
         ncmd++;
         if (ncmd == 32) begin
            check("mosi_command", cmd, 32'h03010000);
            rd_addr = cmd[23:0];
            bitpos  = 0;
         end
      end
   end

   always @(negedge flash_clk) begin
      if (!flash_csb && RESB && ncmd == 32) begin
         flash_miso = fmem[rd_addr[7:0]][7 - bitpos];
         bitpos++;
         if (bitpos == 8) begin
            bitpos  = 0;
            rd_addr = rd_addr + 24'd1;
         end
      end
   end

   // SRAM acceptor with per-byte random latency
   logic force5 = 1'b0;
   int   wcnt = 0;
   int   cur_delay = 0;

   always @(posedge CLK) begin
      #1;
      if (!RESB) begin
         sram_wack = 1'b0;
         wcnt      = 0;
      end else if (sram_wack) begin
         sram_wack = 1'b0;
         wcnt      = 0;
      end else if (sram_wreq) begin
         if (wcnt == 0)
            cur_delay = (force5 && byte_count == 18'd2) ? 5 : int'($urandom_range(0, 3));
         if (wcnt >= cur_delay) sram_wack = 1'b1;
         else wcnt++;
      end
   end

   // Monitor: invariants, phase timing and scoreboard
   logic p_csb = 1'b1, p_sck = 1'b0, p_wreq = 1'b0;
   int   t_csb = 0, t_ref = 0, falls = 0, wlen = 0;

   always @(negedge CLK) begin
      if (!RESB) begin
         p_csb  = 1'b1;
         p_sck  = 1'b0;
         p_wreq = 1'b0;
         falls  = 0;
      end else begin
         check("sck_while_csb_high", {31'd0, flash_csb & flash_clk}, 0);
         check("cpu_resb_while_busy", {31'd0, cpu_resb & busy}, 0);
         check("len0_csb_high", {31'd0, z_csb}, 1);
         if (p_csb && !flash_csb) begin
            t_csb = cyc;
            falls = 0;
         end
         if (!p_sck && flash_clk && falls == 0)
            check("first_sck_rise", cyc - t_csb, 2);
         if (p_sck && !flash_clk) begin
            falls++;
            if (falls == 32) begin
               check("cmd_phase_len", cyc - t_csb, 128);
               t_ref = cyc;
            end
         end
         if (!p_wreq && sram_wreq) begin
            check("byte_time", cyc - t_ref, 32);
            wlen = 0;
         end
         if (p_wreq && !sram_wreq) begin
            t_ref = cyc;
            if (force5 && byte_count == 18'd3) check("wreq_hold_len", wlen, 6);
         end
         if (sram_wreq) begin
            wlen++;
            check("sck_low_in_write", {31'd0, flash_clk}, 0);
            if (exq.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               check("sram_adr", sram_adr, exq[0].adr);
               check("sram_wdata", sram_wdata, exq[0].data);
               check("wrap_adr", w_adr, exq[0].adr_w);
               check("wrap_wdata", w_wdata, exq[0].data);
               if (sram_wack) void'(exq.pop_front());
            end
         end
         p_csb  = flash_csb;
         p_sck  = flash_clk;
         p_wreq = sram_wreq;
      end
   end

   task automatic wait_done();
      int k = 0;
      while (!done && k < 3000) begin
         @(negedge CLK);
         k++;
      end
      check("done_timeout", {31'd0, done}, 1);
   endtask

   task automatic end_checks();
      check("queue_drained", exq.size(), 0);
      check("csb_after", {31'd0, flash_csb}, 1);
      check("byte_count_end", byte_count, NLEN);
      check("sram_adr_end", sram_adr, 19'(SB0 + 19'(NLEN)));
      check("wrap_adr_end", w_adr, 19'h00002);
      check("wrap_count_end", w_count, NLEN);
      @(posedge CLK);
      #1;
      check("cpu_resb_end", {31'd0, cpu_resb}, 1);
      check("busy_end", {31'd0, busy}, 0);
      check("done_end", {31'd0, done}, 1);
   endtask

   task automatic randomize_flash();
      for (int i = 0; i < 256; i++) fmem[i] = 8'($urandom);
   endtask

   task automatic do_reload();
      @(negedge CLK);
      reload = 1'b1;
      @(posedge CLK);
      #1;
      reload = 1'b0;
      check("reload_cpu_resb", {31'd0, cpu_resb}, 0);
      check("reload_done", {31'd0, done}, 0);
      check("reload_count", byte_count, 0);
      check("reload_adr", sram_adr, SB0);
      check("reload_busy", {31'd0, busy}, 1);
      check("len0_reload_done", {31'd0, z_done}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      randomize_flash();
      fmem[0] = 8'hA5;
      fmem[1] = 8'h5A;
      fmem[2] = 8'h00;
      fmem[3] = 8'hFF;
      force5  = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_csb", {31'd0, flash_csb}, 1);
      check("rst_sck", {31'd0, flash_clk}, 0);
      check("rst_mosi", {31'd0, flash_mosi}, 0);
      check("rst_wreq", {31'd0, sram_wreq}, 0);
      check("rst_adr", sram_adr, SB0);
      check("rst_wdata", sram_wdata, 0);
      check("rst_cpu_resb", {31'd0, cpu_resb}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_count", byte_count, 0);

      // Run 1: fixed pattern, byte 2 acknowledged late
      push_copy();
      @(negedge CLK);
      RESB = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      check("len0_busy_early", {31'd0, z_busy}, 1);
      check("len0_done_early", {31'd0, z_done}, 0);
      repeat (8) @(posedge CLK);
      #1;
      check("len0_done", {31'd0, z_done}, 1);
      check("len0_cpu_resb", {31'd0, z_cpu_resb}, 1);
      wait_done();
      end_checks();
      force5 = 1'b0;

      // Run 2: reset during byte 1, full copy restarts
      randomize_flash();
      push_copy();
      do_reload();
      begin
         int k = 0;
         while (byte_count != 18'd1 && k < 3000) begin
            @(negedge CLK);
            k++;
         end
         check("reach_byte1", byte_count, 1);
      end
      repeat ($urandom_range(3, 20)) @(posedge CLK);
      #3;
      RESB = 1'b0;
      #1;
      check("async_rst_csb", {31'd0, flash_csb}, 1);
      check("async_rst_cpu_resb", {31'd0, cpu_resb}, 0);
      check("async_rst_sck", {31'd0, flash_clk}, 0);
      check("async_rst_count", byte_count, 0);
      check("async_rst_adr", sram_adr, SB0);
      push_copy();
      repeat (2) @(negedge CLK);
      RESB = 1'b1;
      wait_done();
      end_checks();

      // Run 3: reload during CMD is ignored
      randomize_flash();
      push_copy();
      do_reload();
      begin
         int k = 0;
         while (flash_csb && k < 100) begin
            @(negedge CLK);
            k++;
         end
         check("csb_fall", {31'd0, flash_csb}, 0);
      end
      repeat (20) @(posedge CLK);
      @(negedge CLK);
      reload = 1'b1;
      @(posedge CLK);
      #1;
      reload = 1'b0;
      check("cmd_reload_csb", {31'd0, flash_csb}, 0);
      check("cmd_reload_busy", {31'd0, busy}, 1);
      wait_done();
      end_checks();

      // Runs 4-6: random data and acknowledge latency
      for (int r = 0; r < 3; r++) begin
         randomize_flash();
         push_copy();
         do_reload();
         wait_done();
         end_checks();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
- Boot-time copier between the on-board QSPI flash (driven in single-bit SPI mode) and the SRAM controller's write port.
- After reset it holds the 65C816 in reset (cpu_resb low) and issues a flash READ (0x03) command.
- It streams LEN bytes from FLASH_BASE into SRAM starting at SRAM_BASE, then releases the CPU.
- It is the stage upstream of the SRAM/CPU bus: it fills the memory the CPU then executes from.

Parameters:
CLK_DIV, 2, SPI half-period in CLK cycles (>=1); one SPI bit = 2*CLK_DIV CLK cycles
START_DELAY, 16, CLK cycles to wait after reset/reload before CSB falls (flash tPU/tCSH)
FLASH_BASE, 24'h010000, first flash byte address sent in the command
SRAM_BASE, 19'h00000, SRAM address for the first byte
LEN, 32768, bytes to copy (0..131072)

Ports:
CLK  in  1  12 MHz system clock; all logic on rising edge
RESB  in  1  asynchronous active-low reset
reload  in  1  one-cycle pulse; restarts the copy when idle/done
flash_csb  out  1  flash chip select, active low
flash_clk  out  1  SPI clock, mode 0
flash_mosi  out  1  to flashIO[0]
flash_miso  in  1  from flashIO[1]
sram_adr  out  19  SRAM write address
sram_wdata  out  8  SRAM write data
sram_wreq  out  1  write request
sram_wack  in  1  write accepted by SRAM controller
cpu_resb  out  1  CPU reset, active low
busy  out  1  copy in progress (WAIT..WRITE)
done  out  1  copy completed since last reset/reload
byte_count  out  18  bytes written so far

Behaviour:
- Reset (RESB=0, asynchronous): flash_csb=1, flash_clk=0, flash_mosi=0, sram_wreq=0, sram_adr=SRAM_BASE, sram_wdata=0, cpu_resb=0, busy=0, done=0, byte_count=0, state=WAIT, all counters cleared.
- On reset release the FSM runs automatically, in the order WAIT, CMD, DATA, WRITE, DONE.
- WAIT: busy=1; count START_DELAY cycles.
  - LEN==0: go to DONE without asserting CSB.
  - Otherwise: on the cycle after the count completes, flash_csb=0 and flash_mosi=bit31 of {8'h03, FLASH_BASE}; go to CMD.
- CMD: shift out 32 bits MSB first.
  - SCK rises CLK_DIV cycles after CSB falls (or after the previous fall) and falls CLK_DIV cycles later.
  - MOSI changes only on the CLK edge where SCK falls.
  - After the 32nd fall, go to DATA; MOSI=0 from then on.
- DATA: 8 SCK periods with the same timing.
  - flash_miso is sampled on the CLK edge that drives SCK high, shifted in MSB first.
  - After the 8th fall (SCK=0): sram_wdata=assembled byte, sram_wreq=1; go to WRITE.
- WRITE: SCK held low, CSB held low (continuous read). sram_adr and sram_wdata are stable while sram_wreq=1.
  - A transfer completes on the first CLK edge with sram_wreq=1 and sram_wack=1. On that edge: byte_count+1, sram_adr+1 (mod 2^19 wrap), sram_wreq=0.
  - If byte_count then equals LEN, go to DONE. Otherwise go to DATA; the next SCK rise is CLK_DIV cycles later.
- DONE: flash_csb=1, flash_clk=0, busy=0, done=1, cpu_resb=1 (registered, one cycle after entry); idle.
- reload: accepted only in DONE.
  - On acceptance: cpu_resb=0, done=0, byte_count=0, sram_adr=SRAM_BASE, state=WAIT, all on the next edge.
  - Ignored in any other state.
- Reset mid-operation: immediate return to reset values, including CSB=1 (terminates the flash command). The full sequence restarts on release.
- cpu_resb is never high while busy=1.
- flash_clk never toggles while flash_csb=1.

Test Plan:
- LEN=4, FLASH_BASE=24'h010000, SRAM_BASE=0, CLK_DIV=2, START_DELAY=16; flash model returns A5,5A,00,FF. Required:
  - MOSI carries 0x03010000 MSB first.
  - SRAM writes (0,A5),(1,5A),(2,00),(3,FF) in order.
  - CSB high afterwards; done=1; cpu_resb=1; byte_count=4.
- Timing with CLK_DIV=2: first SCK rise exactly 2 cycles after CSB falls; CMD phase is exactly 128 CLK cycles; each data byte is 32 cycles plus handshake.
- sram_wack delayed 5 cycles on byte 2: sram_wreq held 6 cycles with adr/data unchanged, no SCK edges during the wait, byte stream uncorrupted.
- RESB pulsed low during DATA of byte 1: CSB=1 and cpu_resb=0 asynchronously; after release the command is reissued and bytes are rewritten from SRAM_BASE.
- SRAM_BASE=19'h7FFFE, LEN=4: writes go to 7FFFE, 7FFFF, 00000, 00001.
- reload: a pulse during CMD is ignored; a pulse after done drives cpu_resb=0 on the next edge and the full copy repeats. With LEN=0: done=1 after START_DELAY, CSB never falls.
